// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the rPLL lock sequencer.
package pll_seq_pkg;

    localparam int PLL_DW = 4;
    localparam logic [PLL_DW-1:0] DUTY_INIT_DEFAULT = 4'b1000;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_READY     = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Gowin rPLL bring-up: RESET pulse, stable-lock detection with timeout and
// bounded retries, then valid/ready driven PSDA/DUTYDA updates while locked.
//
// state     | meaning
// ----------+----------------------------------------------------------
// RESET     | pll_reset held high for RESET_CYCLES
// WAIT_LOCK | waiting for LOCK_STABLE_CYCLES of lock, bounded by timeout
// READY     | locked, accepting cfg updates
// SETTLE    | locked, new phase/duty settling, no updates accepted
// FAIL      | retries exhausted, held until rst_n
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RESET_CYCLES        = 8,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 27000,
    parameter int SETTLE_CYCLES       = 16,
    parameter int MAX_RETRIES         = 3,
    parameter logic [PLL_DW-1:0] DUTY_INIT = DUTY_INIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic              pll_reset_p,
    output logic [PLL_DW-1:0] pll_psda,
    output logic [PLL_DW-1:0] pll_dutyda,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [PLL_DW-1:0] cfg_psda,
    input  logic [PLL_DW-1:0] cfg_dutyda,
    output logic              locked,
    output logic              fail,
    output logic [3:0]        retry_cnt
);

    localparam int CNT_MAX = max_of(max_of(RESET_CYCLES, LOCK_TIMEOUT_CYCLES), SETTLE_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int SW      = $clog2(LOCK_STABLE_CYCLES + 1);

    localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

    pll_state_t        r_state;
    logic [CW-1:0]     r_cnt;
    logic [SW-1:0]     r_stable;
    logic              r_pll_reset;
    logic              r_locked;
    logic              r_fail;
    logic [3:0]        r_retry;
    logic [PLL_DW-1:0] r_psda;
    logic [PLL_DW-1:0] r_dutyda;

    logic              w_lock_s;
    logic [3:0]        w_retry_next;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (pll_lock),
        .o_q   (w_lock_s)
    );

    assign w_retry_next = (r_retry == RETRY_MAX) ? r_retry : r_retry + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RESET;
            r_cnt       <= '0;
            r_stable    <= '0;
            r_pll_reset <= 1'b1;
            r_locked    <= 1'b0;
            r_fail      <= 1'b0;
            r_retry     <= '0;
            r_psda      <= '0;
            r_dutyda    <= DUTY_INIT;
        end else begin
            case (r_state)
                ST_RESET: begin
                    if (r_cnt == RESET_LAST) begin
                        r_state     <= ST_WAIT_LOCK;
                        r_pll_reset <= 1'b0;
                        r_cnt       <= '0;
                        r_stable    <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                ST_WAIT_LOCK: begin
                    // A completed lock takes priority over a simultaneous timeout.
                    if (w_lock_s && (r_stable == STABLE_LAST)) begin
                        r_state  <= ST_READY;
                        r_locked <= 1'b1;
                        r_cnt    <= '0;
                        r_stable <= '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_cnt       <= '0;
                        r_stable    <= '0;
                        r_pll_reset <= 1'b1;
                        r_retry     <= w_retry_next;
                        if (w_retry_next == RETRY_MAX) begin
                            r_state <= ST_FAIL;
                            r_fail  <= 1'b1;
                        end else begin
                            r_state <= ST_RESET;
                        end
                    end else begin
                        r_cnt    <= r_cnt + CW'(1);
                        r_stable <= w_lock_s ? r_stable + SW'(1) : '0;
                    end
                end

                ST_READY: begin
                    if (!w_lock_s) begin
                        r_state     <= ST_RESET;
                        r_pll_reset <= 1'b1;
                        r_locked    <= 1'b0;
                        r_cnt       <= '0;
                    end else if (cfg_valid) begin
                        r_state  <= ST_SETTLE;
                        r_psda   <= cfg_psda;
                        r_dutyda <= cfg_dutyda;
                        r_cnt    <= '0;
                    end
                end

                ST_SETTLE: begin
                    if (!w_lock_s) begin
                        r_state     <= ST_RESET;
                        r_pll_reset <= 1'b1;
                        r_locked    <= 1'b0;
                        r_cnt       <= '0;
                    end else if (r_cnt == SETTLE_LAST) begin
                        r_state <= ST_READY;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                ST_FAIL: begin
                    r_pll_reset <= 1'b1;
                    r_locked    <= 1'b0;
                    r_fail      <= 1'b1;
                end

                default: begin
                    r_state     <= ST_RESET;
                    r_pll_reset <= 1'b1;
                    r_locked    <= 1'b0;
                    r_cnt       <= '0;
                    r_stable    <= '0;
                end
            endcase
        end
    end

    assign cfg_ready   = (r_state == ST_READY) && w_lock_s;
    assign pll_reset   = r_pll_reset;
    assign pll_reset_p = 1'b0;
    assign pll_psda    = r_psda;
    assign pll_dutyda  = r_dutyda;
    assign locked      = r_locked;
    assign fail        = r_fail;
    assign retry_cnt   = r_retry;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with a phase-level reference model
// compared on every falling edge, plus hand-computed timing expectations.
module tb_pll_lock_sequencer;

    localparam int RC = 4;
    localparam int LS = 3;
    localparam int TO = 20;
    localparam int SC = 5;
    localparam int MR = 2;

    localparam int PH_RST    = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_READY  = 2;
    localparam int PH_SETTLE = 3;
    localparam int PH_FAIL   = 4;

    logic       clk;
    logic       rst_n;
    logic       pll_lock;
    logic       pll_reset;
    logic       pll_reset_p;
    logic [3:0] pll_psda;
    logic [3:0] pll_dutyda;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_psda;
    logic [3:0] cfg_dutyda;
    logic       locked;
    logic       fail;
    logic [3:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    int m_phase   = PH_RST;
    int m_el      = 0;
    int m_run     = 0;
    int m_retries = 0;
    int m_psda    = 0;
    int m_duty    = 8;
    bit m_s1      = 0;
    bit m_s2      = 0;
    bit m_ls      = 0;

    pll_lock_sequencer #(
        .RESET_CYCLES        (RC),
        .LOCK_STABLE_CYCLES  (LS),
        .LOCK_TIMEOUT_CYCLES (TO),
        .SETTLE_CYCLES       (SC),
        .MAX_RETRIES         (MR),
        .DUTY_INIT           (4'b1000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .pll_reset_p (pll_reset_p),
        .pll_psda    (pll_psda),
        .pll_dutyda  (pll_dutyda),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_psda    (cfg_psda),
        .cfg_dutyda  (cfg_dutyda),
        .locked      (locked),
        .fail        (fail),
        .retry_cnt   (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_RST; m_el = 0; m_run = 0; m_retries = 0;
        m_psda = 0; m_duty = 8; m_s1 = 0; m_s2 = 0;
    endtask

    // Reference model: phases with elapsed-cycle counts, lock seen through a 2-cycle delay.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_ls = m_s2;
            case (m_phase)
                PH_RST: begin
                    m_el++;
                    if (m_el == RC) begin m_phase = PH_WAIT; m_el = 0; m_run = 0; end
                end
                PH_WAIT: begin
                    m_el++;
                    m_run = m_ls ? m_run + 1 : 0;
                    if (m_run == LS) begin
                        m_phase = PH_READY; m_el = 0;
                    end else if (m_el == TO) begin
                        m_retries++;
                        m_phase = (m_retries >= MR) ? PH_FAIL : PH_RST;
                        m_el = 0;
                    end
                end
                PH_READY: begin
                    if (!m_ls) begin
                        m_phase = PH_RST; m_el = 0;
                    end else if (cfg_valid) begin
                        m_psda = int'(cfg_psda); m_duty = int'(cfg_dutyda);
                        m_phase = PH_SETTLE; m_el = 0;
                    end
                end
                PH_SETTLE: begin
                    if (!m_ls) begin
                        m_phase = PH_RST; m_el = 0;
                    end else begin
                        m_el++;
                        if (m_el == SC) begin m_phase = PH_READY; m_el = 0; end
                    end
                end
                default: ;
            endcase
            m_s2 = m_s1;
            m_s1 = pll_lock;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("m_pll_reset", pll_reset, (m_phase == PH_RST) || (m_phase == PH_FAIL));
            chk("m_pll_reset_p", pll_reset_p, 0);
            chk("m_psda", pll_psda, m_psda);
            chk("m_dutyda", pll_dutyda, m_duty);
            chk("m_locked", locked, (m_phase == PH_READY) || (m_phase == PH_SETTLE));
            chk("m_fail", fail, m_phase == PH_FAIL);
            chk("m_retry_cnt", retry_cnt, m_retries);
            chk("m_cfg_ready", cfg_ready, (m_phase == PH_READY) && m_s2);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic count_reset(input logic lvl, output int n);
        n = 0;
        while (pll_reset === lvl && n < 200) begin @(posedge clk); #1; n++; end
    endtask

    task automatic wait_locked(output int n);
        n = 0;
        while (locked !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pll_reset"}, pll_reset, 1);
        chk({tag, "_psda"}, pll_psda, 0);
        chk({tag, "_dutyda"}, pll_dutyda, 4'b1000);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_fail"}, fail, 0);
        chk({tag, "_retry"}, retry_cnt, 0);
        chk({tag, "_cfg_ready"}, cfg_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; pll_lock = 1'b0; cfg_valid = 1'b0;
        cfg_psda = 4'h0; cfg_dutyda = 4'h0;
        @(posedge clk); #1;
        chk_reset("rst0");
        cyc(1);
        rst_n = 1'b1;

        // normal lock
        count_reset(1'b1, n); chk("reset_pulse_len", n, 4);
        cyc(6);
        pll_lock = 1'b1;
        wait_locked(n); chk("lock_latency", n, 5);
        chk("lock_retry", retry_cnt, 0);
        chk("lock_fail", fail, 0);

        // configuration handshake, then held valid re-accepted after settle
        chk("ready_before_cfg", cfg_ready, 1);
        cfg_psda = 4'h5; cfg_dutyda = 4'h6; cfg_valid = 1'b1;
        cyc(1);
        chk("cfg_psda_5", pll_psda, 5);
        chk("cfg_dutyda_6", pll_dutyda, 6);
        chk("ready_low_after_hs", cfg_ready, 0);
        cfg_psda = 4'h7; cfg_dutyda = 4'h9;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 50) begin cyc(1); n++; end
        chk("settle_len", n, 5);
        chk("psda_held_in_settle", pll_psda, 5);
        cyc(1);
        chk("cfg_psda_7", pll_psda, 7);
        chk("cfg_dutyda_9", pll_dutyda, 9);

        // lock loss during settle
        pll_lock = 1'b0; cfg_valid = 1'b0;
        n = 0;
        while (locked !== 1'b0 && n < 50) begin cyc(1); n++; end
        chk("unlock_latency", n, 3);
        chk("unlock_psda_kept", pll_psda, 7);
        chk("unlock_retry", retry_cnt, 0);

        // glitch in WAIT_LOCK then real relock
        count_reset(1'b1, n); chk("relock_reset_len", n, 4);
        pll_lock = 1'b1; cyc(2);
        pll_lock = 1'b0; cyc(3);
        chk("glitch_no_lock", locked, 0);
        pll_lock = 1'b1;
        wait_locked(n); chk("relock_latency", n, 5);
        chk("relock_retry", retry_cnt, 0);

        // async reset mid-SETTLE
        cfg_psda = 4'h5; cfg_dutyda = 4'h6; cfg_valid = 1'b1;
        cyc(1);
        cfg_valid = 1'b0;
        cyc(2);
        #3 rst_n = 1'b0;
        #1 chk_reset("arst_settle");
        cyc(2);
        chk_reset("arst_settle_hold");
        rst_n = 1'b1;
        count_reset(1'b1, n); chk("restart_reset_len", n, 4);
        wait_locked(n); chk("restart_lock_latency", n, 3);

        // async reset mid-WAIT_LOCK
        pll_lock = 1'b0;
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        count_reset(1'b1, n); chk("wl_reset_len", n, 4);
        cyc(3);
        #3 rst_n = 1'b0;
        #1 chk_reset("arst_wait");
        cyc(1);
        rst_n = 1'b1;

        // no lock: two attempts, then sticky fail
        count_reset(1'b1, n); chk("nolock_pulse1", n, 4);
        count_reset(1'b0, n); chk("nolock_wait1", n, 20);
        count_reset(1'b1, n); chk("nolock_pulse2", n, 4);
        count_reset(1'b0, n); chk("nolock_wait2", n, 20);
        chk("fail_set", fail, 1);
        chk("fail_retry", retry_cnt, 2);
        chk("fail_reset_high", pll_reset, 1);
        pll_lock = 1'b1; cfg_valid = 1'b1;
        cyc(30);
        chk("fail_sticky", fail, 1);
        chk("fail_no_ready", cfg_ready, 0);
        chk("fail_not_locked", locked, 0);
        cfg_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1 chk_reset("arst_fail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
